sprite_blitter: RTL
===================

Name: sprite_blitter

Overview:
- Draw engine between the game FSM and vga_adapter in the 160x120, 24-bit colour Mario design.
- On a start pulse it walks one SPR_W x SPR_H sprite at a given screen position and reads the sprite ROM and the stage-background ROM, both with 1-cycle registered latency.
- It substitutes background colour wherever the sprite pixel equals KEY_COLOUR, and emits one x/y/colour/plot beat per pixel.
- Erase mode redraws pure background over the sprite footprint.

Parameters:
- SPR_W, 12, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.
- SCREEN_W, 160, visible width; also the background ROM row pitch.
- SCREEN_H, 120, visible height.
- KEY_COLOUR, 24'hFFFFFF, transparent sprite colour.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- erase  in  1  latched with start; 1 = draw background only.
- pos_x  in  8  sprite top-left x; latched with start.
- pos_y  in  8  sprite top-left y; latched with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when an operation completes.
- spr_addr  out  15  sprite ROM address = row*SPR_W + col.
- spr_data  in  24  sprite ROM data, valid 1 cycle after spr_addr.
- bg_addr  out  15  background ROM address = (pos_y+row)*SCREEN_W + (pos_x+col).
- bg_data  in  24  background ROM data, valid 1 cycle after bg_addr.
- x  out  8  VGA pixel x.
- y  out  8  VGA pixel y.
- colour  out  24  VGA pixel colour.
- plot  out  1  VGA write enable.

Behaviour:
- Reset (resetn=0 at an edge): state IDLE; busy, done, plot, x, y, colour, spr_addr, bg_addr and counters all 0. This applies mid-operation too: the next cycle shows plot=0 and there is no done pulse.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 latches pos_x, pos_y and erase, clears col and row to 0, and moves to ISSUE.
  - busy is 0 in IDLE and goes to 1 from the next cycle.
- ISSUE:
  - Each cycle drives spr_addr and bg_addr for (col,row), plus a valid/clip flag and pixel coordinates into a 1-stage pipeline register.
  - col increments 0..SPR_W-1. On wrap, col returns to 0 and row increments.
  - After issuing (SPR_W-1, SPR_H-1), move to DRAIN.
- Output stage, one cycle after issue:
  - plot = stage valid AND NOT clipped.
  - x = pos_x+col and y = pos_y+row, both of the issuing pixel.
  - colour = bg_data if erase=1 or spr_data==KEY_COLOUR; otherwise spr_data.
- DRAIN: a single cycle that emits the last pixel, then moves to FINISH.
- FINISH: done=1 for exactly one cycle, busy still 1; then IDLE.
- Timing, with start sampled at edge 0:
  - Addresses are issued at cycles 1..N, where N = SPR_W*SPR_H.
  - Plot beats occur at cycles 2..N+1.
  - done occurs at cycle N+2.
  - busy is high for cycles 1..N+2.
- Clipping:
  - A pixel is clipped if pos_x+col >= SCREEN_W or pos_y+row >= SCREEN_H, computed in 9 bits with no wrap.
  - A clipped pixel still consumes its cycle, has plot=0, and forces bg_addr=0.
- start while busy: ignored, and the latched position does not change.
- start in the same cycle as FINISH: ignored. A new start is accepted only in IDLE.
- Changes on pos_x, pos_y or erase during an operation have no effect.
- Arithmetic:
  - bg_addr is computed at 15 bits; the maximum 119*160+159 = 19199 fits.
  - spr_addr is zero-extended to 15 bits.

Decomposition:
- Shared package holds:
  - SCREEN_W and SCREEN_H.
  - KEY_COLOUR.
  - State encodings for IDLE, ISSUE, DRAIN, FINISH.
  - Default SPR_W and SPR_H.
- One sub-module, blit_counter: a col/row scan counter with wrap and a last-pixel flag.
- The top level holds the FSM, address arithmetic, the pipeline register and the colour mux.

Test Plan:
- Opaque draw: reset, then start with pos=(10,20), erase=0, sprite ROM all 24'hFF0000.
  - Expect 192 plot beats at cycles 2..193, covering x 10..21 and y 20..35 in raster order, all with colour FF0000.
  - Expect a done pulse at cycle 194, then busy=0.
- Transparency: sprite pixel (3,5) = FFFFFF, background ROM returns the address as its data, pos=(10,20).
  - The beat for x=13, y=25 must carry colour = 25*160+13 = 4013.
- Erase: start with erase=1 at pos=(40,50).
  - Every beat carries bg_data for its own (x,y) and sprite data is ignored.
- Clip: pos=(155,110).
  - Only x 155..159 and y 110..119 plot, giving 50 beats; clipped pixels have plot=0.
  - done still occurs at cycle 194.
- Protocol:
  - A second start at cycle 50 is ignored: no position change, and one done only.
  - resetn=0 at cycle 100 gives plot=0, busy=0 and no done from cycle 101; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// sprite_blitter_pkg
//   Shared constants and types for the sprite blitter slice.
//   - DEF_SCREEN_W / DEF_SCREEN_H : visible raster (160x120); DEF_SCREEN_W
//     is also the background ROM row pitch.
//   - DEF_KEY_COLOUR             : sprite colour treated as transparent.
//   - DEF_SPR_W / DEF_SPR_H      : default sprite footprint.
//   - blit_state_t               : draw FSM states.
//   - blit_stage_t               : one-deep pixel pipeline register contents.
package sprite_blitter_pkg;

    localparam int unsigned DEF_SCREEN_W   = 160;
    localparam int unsigned DEF_SCREEN_H   = 120;
    localparam logic [23:0] DEF_KEY_COLOUR = 24'hFFFFFF;
    localparam int unsigned DEF_SPR_W      = 12;
    localparam int unsigned DEF_SPR_H      = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FINISH
    } blit_state_t;

    typedef struct packed {
        logic       valid;
        logic       clip;
        logic [7:0] x;
        logic [7:0] y;
    } blit_stage_t;

endpackage

// File: rtl/sprite_blitter_counter.sv
// blit_counter
//   Raster scan counter over a SPR_W x SPR_H footprint.
//   Ports:
//     clk, resetn : clock, synchronous active-low reset
//     clear       : force col/row to 0 (takes priority over advance)
//     advance     : step one pixel in raster order, wrapping col into row
//     col, row    : current pixel within the sprite
//     last        : high while (col,row) is the final pixel
module blit_counter
    import sprite_blitter_pkg::*;
#(
    parameter int unsigned SPR_W = DEF_SPR_W,
    parameter int unsigned SPR_H = DEF_SPR_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] col,
    output logic [7:0] row,
    output logic       last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == 8'(SPR_W - 1));
    assign row_end = (row == 8'(SPR_H - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Walks one SPR_W x SPR_H sprite at a latched screen position, reading the
//   sprite ROM and the stage-background ROM (both 1-cycle registered latency),
//   and emits one x/y/colour/plot beat per pixel. Sprite pixels equal to
//   KEY_COLOUR, or every pixel in erase mode, take the background colour.
//   Ports:
//     CLOCK_50, resetn   : clock, synchronous active-low reset
//     start, erase       : request pulse (IDLE only) and mode, latched together
//     pos_x, pos_y       : sprite top-left, latched with start
//     busy, done         : operation in progress / one-cycle completion pulse
//     spr_addr, spr_data : sprite ROM port (row*SPR_W + col)
//     bg_addr, bg_data   : background ROM port ((pos_y+row)*SCREEN_W + pos_x+col)
//     x, y, colour, plot : VGA adapter write beat
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int unsigned SPR_W      = DEF_SPR_W,
    parameter int unsigned SPR_H      = DEF_SPR_H,
    parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
    parameter logic [23:0] KEY_COLOUR = DEF_KEY_COLOUR
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        erase,
    input  logic [7:0]  pos_x,
    input  logic [7:0]  pos_y,
    output logic        busy,
    output logic        done,
    output logic [14:0] spr_addr,
    input  logic [23:0] spr_data,
    output logic [14:0] bg_addr,
    input  logic [23:0] bg_data,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic [23:0] colour,
    output logic        plot
);

    blit_state_t state;
    blit_stage_t stage;

    logic [7:0]  lat_x;
    logic [7:0]  lat_y;
    logic        lat_erase;

    logic [7:0]  col;
    logic [7:0]  row;
    logic        last;
    logic        cnt_clear;
    logic        cnt_advance;

    logic [8:0]  px;
    logic [8:0]  py;
    logic        clip;
    logic [14:0] spr_lin;
    logic [14:0] bg_lin;
    logic        issuing;

    assign issuing     = (state == ST_ISSUE);
    assign cnt_clear   = (state == ST_IDLE) && start;
    assign cnt_advance = issuing;

    blit_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_counter (
        .clk     (CLOCK_50),
        .resetn  (resetn),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // Screen coordinates carry a ninth bit so positions near the right or
    // bottom edge clip instead of wrapping back onto the screen.
    assign px   = {1'b0, lat_x} + {1'b0, col};
    assign py   = {1'b0, lat_y} + {1'b0, row};
    assign clip = (px >= 9'(SCREEN_W)) || (py >= 9'(SCREEN_H));

    assign spr_lin = 15'(row) * 15'(SPR_W) + 15'(col);
    assign bg_lin  = 15'(py) * 15'(SCREEN_W) + 15'(px);

    // Addresses are presented combinationally during ISSUE so the ROMs'
    // registered data lines up with the pipeline stage one cycle later.
    assign spr_addr = issuing ? spr_lin : '0;
    assign bg_addr  = (issuing && !clip) ? bg_lin : '0;

    assign plot   = stage.valid && !stage.clip;
    assign x      = stage.x;
    assign y      = stage.y;
    assign colour = !plot ? '0 :
                    (lat_erase || (spr_data == KEY_COLOUR)) ? bg_data : spr_data;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_erase <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done        <= 1'b0;
                    stage.valid <= 1'b0;
                    if (start) begin
                        lat_x     <= pos_x;
                        lat_y     <= pos_y;
                        lat_erase <= erase;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    stage <= '{valid: 1'b1, clip: clip, x: px[7:0], y: py[7:0]};
                    if (last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    stage.valid <= 1'b0;
                    done        <= 1'b1;
                    state       <= ST_FINISH;
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
